// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Resolves memory busy-wait, trap redirects, taken branches, multi-cycle
// (mul/div) operations and load-use hazards into stall, flush and bubble
// controls. Control outputs are combinational from state and inputs. The
// stall and flush performance counters are registered.

module pipeline_hazard_ctrl #(
  parameter int unsigned LD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             busywait_i,
  input  logic             trap_flush_i,
  input  logic             branch_taken_ex_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_is_long_i,
  input  logic             long_done_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hazard_o,
  output logic             id_ex_stall_o,
  output logic             ex_mem_bubble_o,
  output logic             long_start_o,
  output logic             long_abort_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LD_STALL  = 2'd1,
    LONG_WAIT = 2'd2
  } state_t;

  // A single load-use bubble needs no extra state; longer stalls count down.
  localparam bit              LD_MULTI  = (LD_STALL_CYCLES > 1);
  localparam logic [2:0]      LD_RELOAD = 3'(LD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state, state_nxt;
  logic [2:0] stall_cnt, stall_cnt_nxt;
  logic       load_use;
  logic       flush_inc;
  logic       stall_inc;

  // Detect a consumer in ID of the load destination currently in EX (x0 never hazards).
  always_comb begin
    load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
               ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  end

  // Derive control outputs and next state by priority: reset, busywait, trap, then per-state actions.
  always_comb begin
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_hazard_o  = 1'b0;
    id_ex_stall_o   = 1'b0;
    ex_mem_bubble_o = 1'b0;
    long_start_o    = 1'b0;
    long_abort_o    = 1'b0;
    flush_inc       = 1'b0;
    state_nxt       = state;
    stall_cnt_nxt   = stall_cnt;

    if (rst_i) begin
      // Outputs stay low while reset is held. The long unit has its own reset, so no abort pulse is sent.
      state_nxt     = RUN;
      stall_cnt_nxt = 3'd0;
    end else if (busywait_i) begin
      // Memory not ready: freeze the front of the pipe and hold all state.
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      id_ex_stall_o = 1'b1;
    end else if (trap_flush_i) begin
      if_id_flush_o   = 1'b1;
      id_ex_hazard_o  = 1'b1;
      ex_mem_bubble_o = 1'b1;
      long_abort_o    = (state == LONG_WAIT);
      state_nxt       = RUN;
      stall_cnt_nxt   = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken_ex_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_hazard_o = 1'b1;
            flush_inc      = 1'b1;
          end else if (ex_is_long_i) begin
            long_start_o    = 1'b1;
            pc_stall_o      = 1'b1;
            if_id_stall_o   = 1'b1;
            id_ex_stall_o   = 1'b1;
            ex_mem_bubble_o = 1'b1;
            state_nxt       = LONG_WAIT;
          end else if (load_use) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_hazard_o = 1'b1;
            if (LD_MULTI) begin
              stall_cnt_nxt = LD_RELOAD;
              state_nxt     = LD_STALL;
            end else begin
              stall_cnt_nxt = 3'd0;
            end
          end else begin
            state_nxt = RUN;
          end
        end
        LD_STALL: begin
          // EX holds a bubble while the load drains, so only the countdown matters here.
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_hazard_o = 1'b1;
          if (stall_cnt <= 3'd1) begin
            stall_cnt_nxt = 3'd0;
            state_nxt     = RUN;
          end else begin
            stall_cnt_nxt = stall_cnt - 3'd1;
          end
        end
        LONG_WAIT: begin
          // Branches and load-use hazards are ignored until the long unit reports completion.
          if (long_done_i) begin
            state_nxt = RUN;
          end else begin
            pc_stall_o      = 1'b1;
            if_id_stall_o   = 1'b1;
            id_ex_stall_o   = 1'b1;
            ex_mem_bubble_o = 1'b1;
          end
        end
        default: begin
          state_nxt     = RUN;
          stall_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  // A cycle counts as a stall only when the pipe is not frozen by busywait.
  always_comb begin
    stall_inc = pc_stall_o && !busywait_i;
  end

  // Advance the controller state and the load-use countdown.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      stall_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Performance counters: the stall count saturates and the flush count wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (stall_inc && (stall_cycles_o != {CNT_W{1'b1}})) begin
        stall_cycles_o <= stall_cycles_o + CNT_ONE;
      end
      if (flush_inc) begin
        flush_count_o <= flush_count_o + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (LD_STALL_CYCLES=2, CNT_W=4).
// Control outputs are packed as
// {pc_stall, if_id_stall, if_id_flush, id_ex_hazard, id_ex_stall, ex_mem_bubble, long_start, long_abort}.

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [7:0] C_IDLE   = 8'h00;
  localparam logic [7:0] C_LDSTL  = 8'hD0;  // pc, if_id stall, id_ex hazard
  localparam logic [7:0] C_BUSY   = 8'hC8;  // pc, if_id, id_ex stall
  localparam logic [7:0] C_LSTART = 8'hCE;  // four stalls/bubble + long_start
  localparam logic [7:0] C_LWAIT  = 8'hCC;  // four stalls/bubble
  localparam logic [7:0] C_BRANCH = 8'h30;  // if_id flush, id_ex hazard
  localparam logic [7:0] C_TRAP   = 8'h34;  // + ex_mem bubble
  localparam logic [7:0] C_TRAPLW = 8'h35;  // + long_abort

  logic             clk = 1'b0;
  logic             rst, busywait, trap_flush, branch_taken;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_is_long, long_done;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_hazard;
  logic             id_ex_stall, ex_mem_bubble, long_start, long_abort;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [7:0]       ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.LD_STALL_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .busywait_i(busywait), .trap_flush_i(trap_flush),
    .branch_taken_ex_i(branch_taken), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .ex_rd_i(ex_rd),
    .ex_is_load_i(ex_is_load), .ex_is_long_i(ex_is_long), .long_done_i(long_done),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_hazard_o(id_ex_hazard), .id_ex_stall_o(id_ex_stall),
    .ex_mem_bubble_o(ex_mem_bubble), .long_start_o(long_start), .long_abort_o(long_abort),
    .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
  );

  assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_hazard,
                 id_ex_stall, ex_mem_bubble, long_start, long_abort};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; busywait = 1'b1; trap_flush = 1'b1; branch_taken = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_is_long = 1'b1; long_done = 1'b0;

    // Reset overrides every input
    #3;
    chk("rst_ctrl", ctrl, C_IDLE);
    chk("rst_stall_cnt", stall_cycles, 4'd0);
    chk("rst_flush_cnt", flush_count, 4'd0);
    tick();
    chk("rst_hold_ctrl", ctrl, C_IDLE);
    rst = 1'b0; busywait = 1'b0; trap_flush = 1'b0; ex_is_long = 1'b0;
    #1;
    chk("idle_ctrl", ctrl, C_IDLE);

    // Load to x0 is never a hazard
    ex_is_load = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
    #1;
    chk("x0_no_hazard", ctrl, C_IDLE);
    // Matching label but operand not used
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd6;
    #1;
    chk("unused_match", ctrl, C_IDLE);
    tick();
    chk("no_hazard_cnt", stall_cycles, 4'd0);

    // Load-use on rs1: two bubbles
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
    #1;
    chk("lu_rs1_c0", ctrl, C_LDSTL);
    tick();
    ex_is_load = 1'b0; ex_rd = 5'd0;
    #1;
    chk("lu_rs1_c1", ctrl, C_LDSTL);
    tick();
    chk("lu_rs1_done", ctrl, C_IDLE);
    chk("lu_rs1_cnt", stall_cycles, 4'd2);

    // Load-use on rs2
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd7; ex_rd = 5'd7; ex_is_load = 1'b1;
    #1;
    chk("lu_rs2_c0", ctrl, C_LDSTL);
    tick();
    ex_is_load = 1'b0; ex_rd = 5'd0;
    #1;
    chk("lu_rs2_c1", ctrl, C_LDSTL);
    tick();
    chk("lu_rs2_done", ctrl, C_IDLE);
    chk("lu_rs2_cnt", stall_cycles, 4'd4);

    // Busywait inside LD_STALL freezes the countdown and the counters
    ex_rd = 5'd7; ex_is_load = 1'b1;
    #1;
    chk("bw_c0", ctrl, C_LDSTL);
    tick();
    ex_is_load = 1'b0; ex_rd = 5'd0; busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bw_frozen_ctrl", ctrl, C_BUSY);
      tick();
    end
    chk("bw_cnt_frozen", stall_cycles, 4'd5);
    busywait = 1'b0;
    #1;
    chk("bw_remaining", ctrl, C_LDSTL);
    tick();
    chk("bw_after", ctrl, C_IDLE);
    chk("bw_cnt", stall_cycles, 4'd6);

    // Branch beats a simultaneous load-use hazard
    branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
    #1;
    chk("br_ctrl", ctrl, C_BRANCH);
    tick();
    branch_taken = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    #1;
    chk("br_flush_cnt", flush_count, 4'd1);
    chk("br_stall_cnt", stall_cycles, 4'd6);
    chk("br_after", ctrl, C_IDLE);

    // Long done outside LONG_WAIT is ignored
    long_done = 1'b1;
    #1;
    chk("stray_done", ctrl, C_IDLE);
    tick();
    long_done = 1'b0;

    // Long op: start cycle, four waits, completion
    ex_is_long = 1'b1;
    #1;
    chk("long_start", ctrl, C_LSTART);
    tick();
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i == 1);
      ex_is_load = (i == 2); ex_rd = 5'd7;
      #1;
      chk("long_wait", ctrl, C_LWAIT);
      tick();
    end
    branch_taken = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    long_done = 1'b1;
    #1;
    chk("long_done", ctrl, C_IDLE);
    tick();
    long_done = 1'b0; ex_is_long = 1'b0;
    #1;
    chk("long_back_run", ctrl, C_IDLE);
    chk("long_stall_cnt", stall_cycles, 4'd11);
    chk("long_flush_cnt", flush_count, 4'd1);

    // Trap during LONG_WAIT aborts the long unit
    ex_is_long = 1'b1;
    #1;
    chk("trap_lstart", ctrl, C_LSTART);
    tick();
    ex_is_long = 1'b0;
    #1;
    chk("trap_lwait", ctrl, C_LWAIT);
    trap_flush = 1'b1;
    #1;
    chk("trap_in_lwait", ctrl, C_TRAPLW);
    tick();
    trap_flush = 1'b0;
    #1;
    chk("trap_back_run", ctrl, C_IDLE);
    chk("trap_stall_cnt", stall_cycles, 4'd12);

    // Trap in RUN outranks a branch; no abort
    trap_flush = 1'b1; branch_taken = 1'b1;
    #1;
    chk("trap_run", ctrl, C_TRAP);
    tick();
    trap_flush = 1'b0; branch_taken = 1'b0;

    // Reset in LONG_WAIT: outputs drop at once, no abort pulse, counters clear
    ex_is_long = 1'b1;
    tick();
    #1;
    chk("pre_rst_lwait", ctrl, C_LWAIT);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", ctrl, C_IDLE);
    chk("rst_mid_stall", stall_cycles, 4'd0);
    chk("rst_mid_flush", flush_count, 4'd0);
    tick();
    rst = 1'b0; ex_is_long = 1'b0;
    #1;
    chk("rst_mid_after", ctrl, C_IDLE);

    // Stall counter saturates at all-ones
    ex_is_long = 1'b1;
    tick();
    ex_is_long = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", stall_cycles, 4'hF);
    long_done = 1'b1;
    #1;
    chk("sat_done", ctrl, C_IDLE);
    tick();
    long_done = 1'b0;

    // Flush counter wraps
    branch_taken = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("flush_cnt_15", flush_count, 4'hF);
    tick();
    chk("flush_cnt_wrap", flush_count, 4'h0);
    branch_taken = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
